// File: rtl/alu_requester_if.sv
// Command, ALU-side and result signals of alu_requester.
// master = the requester, slave = the environment (command source, ALU, result sink).
interface alu_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  logic [15:0] alu_in;
  logic [1:0]  alu_op_codes;
  logic        alu_valid;
  logic [7:0]  alu_o;
  logic        alu_ready;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_op;
  logic        res_timeout;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_o, alu_ready, res_ready,
    output cmd_ready, alu_in, alu_op_codes, alu_valid, res_valid, res_data, res_op, res_timeout
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_o, alu_ready, res_ready,
    input  cmd_ready, alu_in, alu_op_codes, alu_valid, res_valid, res_data, res_op, res_timeout
  );
endinterface

// File: rtl/alu_requester.sv
// Queues ALU commands and runs them one at a time; push to alu_valid is 1 cycle, result after >=3 edges.
// cmd_ready is !full only; a held result (res_ready low) stalls all further issue.
module alu_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_requester_if.master        bus,
  output logic                   busy,
  output logic [15:0]            done_count
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [17:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] alu_in_q, alu_in_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        alu_valid_q, alu_valid_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic [1:0]  res_op_q, res_op_d;
  logic        res_timeout_q, res_timeout_d;
  logic [15:0] done_count_q, done_count_d;

  logic        empty, full, push, pop;
  logic [17:0] pop_dat;

  // Extra MSB on the pointers separates full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push    = bus.cmd_valid && !full;
  assign pop     = (state_q == IDLE) && !empty;
  assign pop_dat = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    alu_in_d      = alu_in_q;
    alu_op_d      = alu_op_q;
    alu_valid_d   = alu_valid_q;
    wd_cnt_d      = wd_cnt_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_op_d      = res_op_q;
    res_timeout_d = res_timeout_q;
    done_count_d  = done_count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          alu_in_d    = pop_dat[17:2];
          alu_op_d    = pop_dat[1:0];
          alu_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        alu_valid_d = 1'b0;
        wd_cnt_d    = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // alu_ready takes priority over a watchdog expiry in the same cycle.
        if (bus.alu_ready) begin
          res_data_d    = bus.alu_o;
          res_timeout_d = 1'b0;
          res_op_d      = alu_op_q;
          res_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (wd_cnt_q == TO_LAST) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          res_op_d      = alu_op_q;
          res_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d  = 1'b0;
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      alu_in_q      <= '0;
      alu_op_q      <= '0;
      alu_valid_q   <= 1'b0;
      wd_cnt_q      <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
      res_timeout_q <= 1'b0;
      done_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      alu_in_q      <= alu_in_d;
      alu_op_q      <= alu_op_d;
      alu_valid_q   <= alu_valid_d;
      wd_cnt_q      <= wd_cnt_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_op_q      <= res_op_d;
      res_timeout_q <= res_timeout_d;
      done_count_q  <= done_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  assign bus.cmd_ready    = !full;
  assign bus.alu_in       = alu_in_q;
  assign bus.alu_op_codes = alu_op_q;
  assign bus.alu_valid    = alu_valid_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_op       = res_op_q;
  assign bus.res_timeout  = res_timeout_q;
  assign busy             = (state_q != IDLE) || !empty;
  assign done_count       = done_count_q;
endmodule
